// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO types and pointer arithmetic
//
// Purpose: types and helpers used by both sides of the synchronous FIFO.
//   occ_t       occupancy of the 2-entry output stage (head + skid)
//   fifo_level  modulo difference of two wrap-bit pointers
package fifo_pkg;

    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    // Widest pointer fifo_level() accepts; callers zero-extend into it.
    localparam int unsigned FIFO_PTR_MAX_W = 16;

    // (a_wr - a_rd) modulo 2^ptr_w. Callers cast the result down to their
    // own pointer width, so ptr_w only has to clear the borrow bits.
    function automatic logic [FIFO_PTR_MAX_W-1:0] fifo_level(
        input logic [FIFO_PTR_MAX_W-1:0] a_wr,
        input logic [FIFO_PTR_MAX_W-1:0] a_rd,
        input int unsigned               ptr_w
    );
        logic [FIFO_PTR_MAX_W-1:0] diff;
        logic [FIFO_PTR_MAX_W-1:0] mask;
        diff = a_wr - a_rd;
        mask = (FIFO_PTR_MAX_W'(1) << ptr_w) - FIFO_PTR_MAX_W'(1);
        return diff & mask;
    endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// rtl/fifo_out_stage.sv - 2-entry head/skid output register for FIFO reads
//
// Purpose: holds up to two words returned from RAM and presents the oldest
// on a first-word-fall-through valid/ready output.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   push        a RAM word arrives this cycle (push_data)
//   pop         consumer takes the head word this cycle (valid & ready)
//   occ         current occupancy (OCC_0/1/2)
//   m_valid     head word available
//   m_data      head word
import fifo_pkg::*;

module fifo_out_stage #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output occ_t         occ,
    output logic         m_valid,
    output logic [W-1:0] m_data
);

    occ_t         r_occ;
    logic         r_valid;
    logic [W-1:0] r_head;
    logic [W-1:0] r_skid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_occ   <= OCC_0;
            r_valid <= 1'b0;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            case (r_occ)
                OCC_0: begin
                    if (push) begin
                        r_head  <= push_data;
                        r_occ   <= OCC_1;
                        r_valid <= 1'b1;
                    end
                end
                OCC_1: begin
                    if (push && !pop) begin
                        r_skid <= push_data;
                        r_occ  <= OCC_2;
                    end else if (push && pop) begin
                        // head leaves while the new word takes its place
                        r_head <= push_data;
                    end else if (pop) begin
                        r_occ   <= OCC_0;
                        r_valid <= 1'b0;
                    end
                end
                OCC_2: begin
                    if (pop) begin
                        r_head <= r_skid;
                        if (push) begin
                            r_skid <= push_data;
                        end else begin
                            r_occ <= OCC_1;
                        end
                    end
                end
                default: begin
                    r_occ   <= OCC_0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign occ     = r_occ;
    assign m_valid = r_valid;
    assign m_data  = r_head;

endmodule

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - read side of the synchronous FIFO
//
// Purpose: issues RAM reads while the FIFO is non-empty and the output
// stage has room for every outstanding word, and tracks the read pointer.
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   wr_ptr       write pointer (A+1 bits, same clock domain)
//   rd_ptr       read pointer (words issued from RAM, A+1 bits)
//   mem_ren      RAM read enable
//   mem_raddr    RAM read address (rd_ptr low A bits)
//   mem_rdata    RAM read data, one cycle after mem_ren
//   m_valid, m_ready, m_data   first-word-fall-through output
//   mem_empty    rd_ptr == wr_ptr
//   mem_level    wr_ptr - rd_ptr modulo 2^(A+1)
import fifo_pkg::*;

module fifo_read_ctrl #(
    parameter int A = 4,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [A:0]   wr_ptr,
    output logic [A:0]   rd_ptr,
    output logic         mem_ren,
    output logic [A-1:0] mem_raddr,
    input  logic [W-1:0] mem_rdata,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         mem_empty,
    output logic [A:0]   mem_level
);

    localparam int PW = A + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] r_rd_ptr;
    logic          r_inflight;

    occ_t          w_occ;
    logic          w_valid;
    logic          w_pop;
    logic          w_empty;
    logic          w_ren;
    logic [2:0]    w_credit;
    logic [PW-1:0] w_level;

    assign w_empty = (wr_ptr == r_rd_ptr);
    assign w_level = PW'(fifo_level(FIFO_PTR_MAX_W'(wr_ptr),
                                    FIFO_PTR_MAX_W'(r_rd_ptr), PW));
    assign w_pop   = w_valid & m_ready;

    // Words that will be held after this edge if no new read is issued.
    // A pop can only happen with a word in the stage, so this never wraps.
    assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Only issue if the returning word is certain to find a free slot.
    // Combinational from m_ready so a popping consumer keeps 1 word/cycle.
    assign w_ren = rstn & ~w_empty & (w_credit < 3'd2);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_ren) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_inflight <= w_ren;
        end
    end

    fifo_out_stage #(
        .W(W)
    ) u_out_stage (
        .clk       (clk),
        .rstn      (rstn),
        .push      (r_inflight),
        .push_data (mem_rdata),
        .pop       (w_pop),
        .occ       (w_occ),
        .m_valid   (w_valid),
        .m_data    (m_data)
    );

    assign rd_ptr    = r_rd_ptr;
    assign mem_ren   = w_ren;
    assign mem_raddr = r_rd_ptr[A-1:0];
    assign m_valid   = w_valid;
    assign mem_empty = w_empty;
    assign mem_level = w_level;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - self-checking bench for fifo_read_ctrl
module tb_fifo_read_ctrl;

    localparam int A     = 4;
    localparam int W     = 32;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [A:0]   wr_ptr = '0;
    logic [A:0]   rd_ptr;
    logic         mem_ren;
    logic [A-1:0] mem_raddr;
    logic [W-1:0] mem_rdata = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic         mem_empty;
    logic [A:0]   mem_level;

    logic [W-1:0] ram [DEPTH];

    fifo_read_ctrl #(.A(A), .W(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .mem_ren   (mem_ren),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .mem_empty (mem_empty),
        .mem_level (mem_level)
    );

    always #5 clk = ~clk;

    // RAM with one-cycle read latency
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= ram[mem_raddr];
    end

    int           n_total = 0;
    int           n_bad   = 0;
    logic [W-1:0] exp_q[$];
    int unsigned  popped;
    logic         prev_hold;
    logic [W-1:0] prev_data;
    logic [A-1:0] addrs[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Per-cycle reference checks at the falling edge: every word leaves in
    // write order, nothing appears that was not written, output holds
    // steady under backpressure, and at most 2 words are ever held.
    task automatic mon_cycle();
        logic [A:0] lv;
        logic [A:0] held;
        if (!rstn) begin
            prev_hold = 1'b0;
            return;
        end
        lv   = wr_ptr - rd_ptr;
        held = rd_ptr - (A+1)'(popped);
        chk("raddr", 32'(mem_raddr), 32'(rd_ptr[A-1:0]));
        chk("level", 32'(mem_level), 32'(lv));
        chk("empty", 32'(mem_empty), 32'(lv == 0));
        chk("level_le_depth", 32'(mem_level <= (A+1)'(DEPTH)), 32'd1);
        chk("held_le2", 32'(held <= 2), 32'd1);
        if (prev_hold) begin
            chk("hold_valid", 32'(m_valid), 32'd1);
            chk("hold_data", m_data, prev_data);
        end
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                chk("stale_word", 32'(m_valid), 32'd0);
            end else begin
                chk("head_data", m_data, exp_q[0]);
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
        prev_hold = m_valid & ~m_ready;
        prev_data = m_data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write side: n words land in RAM and wr_ptr advances at this edge.
    task automatic write_words(input int n, input logic [W-1:0] base, input bit rnd);
        logic [W-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = rnd ? W'($urandom) : base + W'(i);
            ram[wr_ptr[A-1:0]] = d;
            exp_q.push_back(d);
            wr_ptr = wr_ptr + 1'b1;
        end
    endtask

    task automatic do_reset();
        rstn    = 1'b0;
        wr_ptr  = '0;
        m_ready = 1'b0;
        exp_q.delete();
        popped  = 0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < budget) begin
            step();
            t++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int t;
        t = 0;
        @(negedge clk);
        while (!m_valid && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(m_valid), 32'd1);
    endtask

    initial begin
        popped    = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;

        // reset state
        step();
        step();
        @(negedge clk);
        chk("rst_rd_ptr", 32'(rd_ptr), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_ren", 32'(mem_ren), 32'd0);
        chk("rst_empty", 32'(mem_empty), 32'd1);
        chk("rst_level", 32'(mem_level), 32'd0);

        fork
            forever begin
                @(negedge clk);
                mon_cycle();
            end
        join_none

        // single word latency
        step();
        rstn    = 1'b1;
        m_ready = 1'b1;
        step();
        write_words(1, 32'hA5A5_0001, 1'b0);
        @(negedge clk);
        chk("lat_ren", 32'(mem_ren), 32'd1);
        chk("lat_raddr", 32'(mem_raddr), 32'd0);
        step();
        @(negedge clk);
        chk("lat_rd_ptr", 32'(rd_ptr), 32'd1);
        chk("lat_not_yet", 32'(m_valid), 32'd0);
        step();
        @(negedge clk);
        chk("lat_valid", 32'(m_valid), 32'd1);
        chk("lat_data", m_data, 32'hA5A5_0001);
        step();
        @(negedge clk);
        chk("lat_empty", 32'(mem_empty), 32'd1);
        chk("lat_gone", 32'(m_valid), 32'd0);

        // streaming 16 words at full rate
        step();
        do_reset();
        m_ready = 1'b1;
        write_words(16, 32'd0, 1'b0);
        wait_valid("stream_start", 10);
        for (int i = 0; i < 16; i++) begin
            chk("stream_valid", 32'(m_valid), 32'd1);
            @(negedge clk);
        end
        chk("stream_rd_ptr", 32'(rd_ptr), 32'd16);
        chk("stream_level", 32'(mem_level), 32'd0);
        chk("stream_done", 32'(m_valid), 32'd0);

        // backpressure then toggling ready
        step();
        do_reset();
        write_words(10, 32'd100, 1'b0);
        repeat (8) step();
        @(negedge clk);
        chk("bp_rd_ptr", 32'(rd_ptr), 32'd2);
        chk("bp_level", 32'(mem_level), 32'd8);
        chk("bp_ren", 32'(mem_ren), 32'd0);
        step();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            m_ready = ~m_ready;
            step();
        end
        chk("bp_drain", exp_q.size(), 0);
        chk("bp_count", popped, 10);

        // pointer wrap from 30
        do_reset();
        m_ready = 1'b1;
        write_words(16, 32'd0, 1'b1);
        drain("wrap_pre1", 60);
        write_words(14, 32'd0, 1'b1);
        drain("wrap_pre2", 60);
        repeat (3) step();
        chk("wrap_start", 32'(rd_ptr), 32'd30);
        addrs.delete();
        write_words(4, 32'hC0DE_0000, 1'b0);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (mem_ren) addrs.push_back(mem_raddr);
        end
        chk("wrap_nreads", addrs.size(), 4);
        if (addrs.size() == 4) begin
            chk("wrap_a0", 32'(addrs[0]), 32'd14);
            chk("wrap_a1", 32'(addrs[1]), 32'd15);
            chk("wrap_a2", 32'(addrs[2]), 32'd0);
            chk("wrap_a3", 32'(addrs[3]), 32'd1);
        end
        chk("wrap_rd_ptr", 32'(rd_ptr), 32'd2);
        chk("wrap_drain", exp_q.size(), 0);

        // pop and return in the same cycle with one word held
        step();
        do_reset();
        m_ready = 1'b1;
        write_words(2, 32'h5100_0000, 1'b0);
        wait_valid("sim_start", 10);
        chk("sim_w0", m_data, 32'h5100_0000);
        @(negedge clk);
        chk("sim_valid", 32'(m_valid), 32'd1);
        chk("sim_w1", m_data, 32'h5100_0001);

        // full memory: one drained word allows exactly one more read
        step();
        do_reset();
        write_words(2, 32'h0F00_0000, 1'b0);
        repeat (4) step();
        write_words(16, 32'h0F10_0000, 1'b0);
        @(negedge clk);
        chk("full_level", 32'(mem_level), 32'd16);
        chk("full_ren", 32'(mem_ren), 32'd0);
        chk("full_rd_ptr", 32'(rd_ptr), 32'd2);
        step();
        m_ready = 1'b1;
        @(negedge clk);
        chk("full_ren_pop", 32'(mem_ren), 32'd1);
        step();
        m_ready = 1'b0;
        repeat (4) step();
        @(negedge clk);
        chk("full_rd_ptr2", 32'(rd_ptr), 32'd3);
        chk("full_level2", 32'(mem_level), 32'd15);
        step();
        m_ready = 1'b1;
        drain("full_drain", 60);

        // reset mid-stream with both stage entries full
        do_reset();
        write_words(5, 32'hDEAD_0000, 1'b0);
        repeat (6) step();
        @(negedge clk);
        chk("mid_pre_valid", 32'(m_valid), 32'd1);
        step();
        rstn    = 1'b0;
        wr_ptr  = '0;
        exp_q.delete();
        popped  = 0;
        #1;
        chk("mid_valid", 32'(m_valid), 32'd0);
        chk("mid_rd_ptr", 32'(rd_ptr), 32'd0);
        chk("mid_ren", 32'(mem_ren), 32'd0);
        step();
        step();
        rstn    = 1'b1;
        m_ready = 1'b1;
        repeat (6) step();
        @(negedge clk);
        chk("mid_no_stale", 32'(m_valid), 32'd0);

        // randomized traffic against the queue model
        step();
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                int n;
                n = $urandom_range(1, 3);
                if (exp_q.size() + n <= DEPTH) write_words(n, 32'd0, 1'b1);
            end
            step();
        end
        m_ready = 1'b1;
        drain("rand_drain", 100);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
